// File: rtl/aes_sel_reg_chk.sv
// aes_sel_reg_chk: multi-channel registered sparse selector with legality checker.
// Each channel stores one sparse-encoded mux selector. Incoming writes and stored
// values are checked every cycle; any violation produces a per-channel error pulse,
// bumps a saturating error-cycle counter and latches a sticky fatal alert.
// Optional feature: define AES_SEL_CHK_SHADOW_EN to add an inverted shadow copy of
// every channel whose mismatch against the primary register is a storage error.
module aes_sel_reg_chk #(
  parameter int unsigned          NumCh    = 2,
  parameter int unsigned          Width    = 5,
  parameter int unsigned          Num      = 3,
  parameter logic [Num*Width-1:0] LegalSel = {5'b00011, 5'b11101, 5'b01110},
  parameter logic [Width-1:0]     ResetSel = 5'b01110,
  parameter int unsigned          CntW     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumCh-1:0]       sel_we_i,
  input  logic [NumCh*Width-1:0] sel_i,
  output logic [NumCh*Width-1:0] sel_o,
  output logic [NumCh-1:0]       err_ch_o,
  output logic                   alert_fatal_o,
  output logic [CntW-1:0]        err_cnt_o
);

  // Sparse state encoding: every pair of states differs in at least two bits,
  // so a single flipped state bit lands on an unused code and forces FATAL.
  localparam logic [2:0] ST_INIT  = 3'b011;
  localparam logic [2:0] ST_RUN   = 3'b101;
  localparam logic [2:0] ST_FATAL = 3'b110;

  // Exact match against the table of legal encodings.
  function automatic logic is_legal(input logic [Width-1:0] v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(Num); i++) begin
      if (v == LegalSel[i*Width +: Width]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Legal encodings must be distinct and at least Hamming distance 2 apart.
  function automatic bit legal_set_ok();
    bit ok;
    logic [Width-1:0] diff;
    int ones;
    ok = 1'b1;
    for (int i = 0; i < int'(Num); i++) begin
      for (int j = i + 1; j < int'(Num); j++) begin
        diff = LegalSel[i*Width +: Width] ^ LegalSel[j*Width +: Width];
        ones = 0;
        for (int b = 0; b < int'(Width); b++) ones += int'(diff[b]);
        if (ones < 2) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Elaboration-time parameter sanity checks.
  if (Num < 2 || Num > 8) begin : g_chk_num
    $error("aes_sel_reg_chk: Num must be within 2..8");
  end
  if (!is_legal(ResetSel)) begin : g_chk_reset
    $error("aes_sel_reg_chk: ResetSel is not one of LegalSel");
  end
  if (!legal_set_ok()) begin : g_chk_dist
    $error("aes_sel_reg_chk: LegalSel entries must be distinct with Hamming distance >= 2");
  end

  logic [2:0]             r_state;
  logic [NumCh*Width-1:0] r_sel;
  logic [NumCh-1:0]       r_err_ch;
  logic                   r_alert;
  logic [CntW-1:0]        r_err_cnt;

  logic [2:0]             w_state_next;
  logic                   w_run;
  logic [NumCh-1:0]       w_in_legal;
  logic [NumCh-1:0]       w_cur_legal;
  logic [NumCh-1:0]       w_wr_ok;
  logic [NumCh-1:0]       w_write_err;
  logic [NumCh-1:0]       w_store_err;
  logic [NumCh-1:0]       w_err_next;
  logic                   w_any_err;
  logic [NumCh*Width-1:0] w_sel_next;
  logic [CntW-1:0]        w_cnt_next;

  // Writes are only accepted in RUN; INIT and FATAL (and any corrupt state) ignore them.
  assign w_run = (r_state == ST_RUN);

`ifdef AES_SEL_CHK_SHADOW_EN
  logic [NumCh*Width-1:0] r_shadow;
  logic [NumCh*Width-1:0] w_shadow_next;
`endif

  for (genvar gi = 0; gi < int'(NumCh); gi++) begin : g_ch
    logic [Width-1:0] w_cur;
    logic [Width-1:0] w_in;
    assign w_cur = r_sel[gi*Width +: Width];
    assign w_in  = sel_i[gi*Width +: Width];

    assign w_in_legal[gi]  = is_legal(w_in);
    assign w_cur_legal[gi] = is_legal(w_cur);
    assign w_wr_ok[gi]     = w_run & sel_we_i[gi] & w_in_legal[gi];
    assign w_write_err[gi] = w_run & sel_we_i[gi] & ~w_in_legal[gi];

    // Rejected writes leave the stored value untouched.
    assign w_sel_next[gi*Width +: Width] = w_wr_ok[gi] ? w_in : w_cur;

`ifdef AES_SEL_CHK_SHADOW_EN
    logic [Width-1:0] w_shd;
    assign w_shd = r_shadow[gi*Width +: Width];
    // Shadow follows accepted writes only, so a corrupted shadow stays corrupted.
    assign w_shadow_next[gi*Width +: Width] = w_wr_ok[gi] ? ~w_in : w_shd;
    assign w_store_err[gi] = ~w_cur_legal[gi] | (w_cur != ~w_shd);
`else
    assign w_store_err[gi] = ~w_cur_legal[gi];
`endif

    assign w_err_next[gi] = w_write_err[gi] | w_store_err[gi];
  end

  assign w_any_err = |w_err_next;

  // Next-state logic: any error or a corrupt state code ends in FATAL.
  always_comb begin
    w_state_next = ST_FATAL;
    case (r_state)
      ST_INIT:  w_state_next = w_any_err ? ST_FATAL : ST_RUN;
      ST_RUN:   w_state_next = w_any_err ? ST_FATAL : ST_RUN;
      ST_FATAL: w_state_next = ST_FATAL;
      default:  w_state_next = ST_FATAL;
    endcase
  end

  // Saturating count of cycles that produce at least one channel error.
  assign w_cnt_next = (w_any_err && (r_err_cnt != {CntW{1'b1}})) ?
                      r_err_cnt + CntW'(1) : r_err_cnt;

  // Control state, error pulses, sticky alert and error counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_INIT;
      r_err_ch  <= '0;
      r_alert   <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_err_ch  <= w_err_next;
      r_alert   <= r_alert | (w_state_next == ST_FATAL);
      r_err_cnt <= w_cnt_next;
    end
  end

  // Selector storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sel <= {NumCh{ResetSel}};
    end else begin
      r_sel <= w_sel_next;
    end
  end

`ifdef AES_SEL_CHK_SHADOW_EN
  // Inverted shadow storage, updated in lockstep with the primary register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shadow <= {NumCh{~ResetSel}};
    end else begin
      r_shadow <= w_shadow_next;
    end
  end
`endif

  assign sel_o         = r_sel;
  assign err_ch_o      = r_err_ch;
  assign alert_fatal_o = r_alert;
  assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_aes_sel_reg_chk.sv
// Scoreboard bench for aes_sel_reg_chk (default parameters).
// The stimulus process steps a behavioural model and queues the expected outputs;
// a monitor pops one entry per clock and compares it with the DUT.
module tb_aes_sel_reg_chk;

  localparam logic [4:0] RS = 5'b01110;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [1:0] sel_we_i;
  logic [9:0] sel_i;
  logic [9:0] sel_o;
  logic [1:0] err_ch_o;
  logic       alert_fatal_o;
  logic [7:0] err_cnt_o;

  aes_sel_reg_chk dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sel_we_i      (sel_we_i),
    .sel_i         (sel_i),
    .sel_o         (sel_o),
    .err_ch_o      (err_ch_o),
    .alert_fatal_o (alert_fatal_o),
    .err_cnt_o     (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [9:0] sel;
    logic [1:0] err;
    logic       alert;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: phase 0 = first cycle after reset, 1 = running, 2 = fatal.
  logic [4:0] legal_tab [3] = '{5'b01110, 5'b11101, 5'b00011};
  logic [4:0] m_sel [2];
  int         m_phase;
  logic       m_alert;
  int         m_cnt;

  // Fault injection controls shared with the model.
  bit         inj_sel_on = 1'b0;
  logic [9:0] inj_sel_val;
  bit         inj_sh_on = 1'b0;

  function automatic bit m_legal(input logic [4:0] v);
    foreach (legal_tab[i]) if (legal_tab[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel[0] = RS;
    m_sel[1] = RS;
    m_phase  = 0;
    m_alert  = 1'b0;
    m_cnt    = 0;
  endtask

  // One clock: drive inputs, predict the post-edge outputs, queue them, advance.
  task automatic cycle(input logic [1:0] we, input logic [4:0] s0, input logic [4:0] s1);
    exp_t e;
    logic [4:0] in_v [2];
    logic [4:0] stored;
    logic [1:0] err;
    sel_we_i = we;
    sel_i    = {s1, s0};
    in_v[0]  = s0;
    in_v[1]  = s1;
    if (!rst_ni) begin
      model_reset();
      e = '{sel: {RS, RS}, err: 2'b00, alert: 1'b0, cnt: 8'd0};
    end else begin
      err = 2'b00;
      for (int c = 0; c < 2; c++) begin
        stored = inj_sel_on ? inj_sel_val[c*5 +: 5] : m_sel[c];
        err[c] = !m_legal(stored) || (inj_sh_on && c == 1) ||
                 (m_phase == 1 && we[c] && !m_legal(in_v[c]));
        if (m_phase == 1 && we[c] && m_legal(in_v[c]) && !inj_sel_on) m_sel[c] = in_v[c];
      end
      if (err != 2'b00 && m_cnt < 255) m_cnt++;
      m_phase = (m_phase == 2 || err != 2'b00) ? 2 : 1;
      if (m_phase == 2) m_alert = 1'b1;
      e.sel   = inj_sel_on ? inj_sel_val : {m_sel[1], m_sel[0]};
      e.err   = err;
      e.alert = m_alert;
      e.cnt   = 8'(m_cnt);
    end
    exp_q.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 5'b00000, 5'b00000);
  endtask

  // Asynchronous reset assertion, checked right away, then held for two clocks.
  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst_sel",   32'(sel_o),         32'({RS, RS}));
    chk("rst_err",   32'(err_ch_o),      32'd0);
    chk("rst_alert", 32'(alert_fatal_o), 32'd0);
    chk("rst_cnt",   32'(err_cnt_o),     32'd0);
    model_reset();
    idle(2);
    rst_ni = 1'b1;
  endtask

  function automatic logic [4:0] rand_sel();
    if ($urandom_range(0, 15) == 0) return 5'($urandom);
    return legal_tab[$urandom_range(0, 2)];
  endfunction

  // Monitor: one comparison set per clock for which an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("t=%0t sel=%h err=%b alert=%b cnt=%0d (exp sel=%h err=%b alert=%b cnt=%0d)",
                 $time, sel_o, err_ch_o, alert_fatal_o, err_cnt_o, e.sel, e.err, e.alert, e.cnt);
        chk("sel_o",   32'(sel_o),         32'(e.sel));
        chk("err_ch",  32'(err_ch_o),      32'(e.err));
        chk("alert",   32'(alert_fatal_o), 32'(e.alert));
        chk("err_cnt", 32'(err_cnt_o),     32'(e.cnt));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni   = 1'b0;
    sel_we_i = 2'b00;
    sel_i    = '0;
    model_reset();
    idle(2);
    rst_ni = 1'b1;
    // INIT cycle: this legal write must be ignored.
    cycle(2'b01, 5'b11101, 5'b00000);
    idle(3);
    // Legal write to ch0, then illegal write to ch1, then ignored write in FATAL.
    cycle(2'b01, 5'b11101, 5'b00000);
    idle(1);
    cycle(2'b10, 5'b00000, 5'b11111);
    cycle(2'b01, 5'b00011, 5'b00000);
    idle(2);
    // Reset while in FATAL; legal write in INIT ignored.
    do_reset();
    cycle(2'b10, 5'b00000, 5'b11101);
    idle(2);
    // Corrupt stored ch0 for three cycles.
    inj_sel_val = {m_sel[1], 5'b00000};
    inj_sel_on  = 1'b1;
    force dut.r_sel = inj_sel_val;
    idle(3);
    release dut.r_sel;
    inj_sel_on = 1'b0;
    do_reset();
    // Random episodes, each starting from reset.
    for (int ep = 0; ep < 20; ep++) begin
      for (int i = 0; i < 25; i++) cycle(2'($urandom_range(0, 3)), rand_sel(), rand_sel());
      do_reset();
    end
    // Long storage corruption: the counter must stop at its maximum.
    idle(2);
    inj_sel_val = {5'b10101, m_sel[0]};
    inj_sel_on  = 1'b1;
    force dut.r_sel = inj_sel_val;
    idle(260);
    release dut.r_sel;
    inj_sel_on = 1'b0;
    do_reset();
`ifdef AES_SEL_CHK_SHADOW_EN
    // Flip one shadow bit of ch1 while running.
    idle(2);
    force dut.r_shadow = {~m_sel[1] ^ 5'b00001, ~m_sel[0]};
    inj_sh_on = 1'b1;
    idle(1);
    release dut.r_shadow;
    inj_sh_on = 1'b0;
    do_reset();
`endif
    idle(2);
    @(posedge clk_i);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
